// File: rtl/if_fetch_stage.sv
// IF stage: PC register, imem req/ack fetch FSM with hold buffer, and IF/ID register.
// Optional FETCH_PERF_EN macro adds PerfFetched/PerfStall event counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        BranchFlush,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr_IFID,
  output logic [31:0] PCPlus4_IFID,
  output logic        Valid_IFID,
  output logic [5:0]  OpCode,
  output logic [5:0]  Func,
  output logic [4:0]  RegRS_IFID,
  output logic [4:0]  RegRT_IFID,
  output logic        FetchBusy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] PerfFetched,
  output logic [31:0] PerfStall
`endif
);

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] hold_q, hold_d;
  logic        discard_q, discard_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic        load;
  logic [31:0] load_word;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    hold_d    = hold_q;
    discard_d = discard_q;
    load      = 1'b0;
    load_word = '0;
    unique case (state_q)
      // A redirect while the request is going out poisons that request as well.
      S_ISSUE: begin
        addr_d    = pc_q;
        discard_d = Redirect;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack) begin
          state_d   = S_ISSUE;
          discard_d = 1'b0;
          if (!discard_q && !Redirect) begin
            if (IFIDWrite) begin
              load      = 1'b1;
              load_word = imem_rdata;
            end else begin
              hold_d  = imem_rdata;
              state_d = S_HOLD;
            end
          end
        end else if (Redirect) begin
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (Redirect) begin
          state_d = S_ISSUE;
        end else if (IFIDWrite) begin
          load      = 1'b1;
          load_word = hold_q;
          state_d   = S_ISSUE;
        end
      end
      default: state_d = S_ISSUE;
    endcase
  end

  // PC only moves on redirect or on a delivered word, so pc_q still names the fetched word here.
  always_comb begin
    pc_d = pc_q;
    if (Redirect) begin
      pc_d = RedirectPC & ~32'd3;
    end else if (load && PCWrite) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_comb begin
    instr_d = instr_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (BranchFlush) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (load) begin
      instr_d = load_word;
      pcp4_d  = pc_q + 32'd4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_ISSUE;
      pc_q      <= RESET_PC & ~32'd3;
      addr_q    <= RESET_PC & ~32'd3;
      hold_q    <= '0;
      discard_q <= 1'b0;
      instr_q   <= NOP_WORD;
      pcp4_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      hold_q    <= hold_d;
      discard_q <= discard_d;
      instr_q   <= instr_d;
      pcp4_q    <= pcp4_d;
      valid_q   <= valid_d;
    end
  end

  // Request is gated by reset so it drops immediately when rst_n falls mid-fetch.
  assign imem_req     = rst_n && (state_q != S_HOLD);
  assign imem_addr    = (state_q == S_ISSUE) ? pc_q : addr_q;
  assign FetchBusy    = (state_q == S_WAIT) && !imem_ack && IFIDWrite;
  assign Instr_IFID   = instr_q;
  assign PCPlus4_IFID = pcp4_q;
  assign Valid_IFID   = valid_q;
  assign OpCode       = instr_q[31:26];
  assign Func         = instr_q[5:0];
  assign RegRS_IFID   = instr_q[25:21];
  assign RegRT_IFID   = instr_q[20:16];

`ifdef FETCH_PERF_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    fetched_d = fetched_q;
    stall_d   = stall_q;
    if (load && !BranchFlush) begin
      fetched_d = fetched_q + 32'd1;
    end
    if (FetchBusy || (state_q == S_HOLD)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetched_q <= '0;
      stall_q   <= '0;
    end else begin
      fetched_q <= fetched_d;
      stall_q   <= stall_d;
    end
  end

  assign PerfFetched = fetched_q;
  assign PerfStall   = stall_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed phases plus random control traffic against a
// transaction-level model (outstanding request, delivered-word queue, IF/ID contents).
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCWrite, IFIDWrite, BranchFlush, Redirect;
  logic [31:0] RedirectPC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instr_IFID, PCPlus4_IFID;
  logic        Valid_IFID;
  logic [5:0]  OpCode, Func;
  logic [4:0]  RegRS_IFID, RegRT_IFID;
  logic        FetchBusy;
`ifdef FETCH_PERF_EN
  logic [31:0] PerfFetched, PerfStall;
`endif

  always #5 clk = ~clk;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .BranchFlush(BranchFlush), .Redirect(Redirect), .RedirectPC(RedirectPC),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .Instr_IFID(Instr_IFID), .PCPlus4_IFID(PCPlus4_IFID),
    .Valid_IFID(Valid_IFID), .OpCode(OpCode), .Func(Func),
    .RegRS_IFID(RegRS_IFID), .RegRT_IFID(RegRT_IFID), .FetchBusy(FetchBusy)
`ifdef FETCH_PERF_EN
    , .PerfFetched(PerfFetched), .PerfStall(PerfStall)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_waiting, m_discard, m_valid;
  logic [31:0] m_pc, m_addr, m_instr, m_pcp4, m_fetched, m_stall;
  logic [31:0] m_held[$];
  int          wait_cnt, lat, lat_cfg, stall_left;
  bit          force_ack, found;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic bit ack_now();
    return force_ack || (m_waiting && (wait_cnt + 1 >= lat));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_waiting = 0; m_discard = 0; m_valid = 0;
    m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0;
    m_fetched = 32'h0; m_stall = 32'h0;
    m_held.delete();
    wait_cnt = 0; lat = 1;
  endtask

  task automatic check_reset_values();
    check("rst_req", imem_req, 0);
    check("rst_instr", Instr_IFID, 32'h0);
    check("rst_pcp4", PCPlus4_IFID, 32'h0);
    check("rst_valid", Valid_IFID, 0);
    check("rst_busy", FetchBusy, 0);
    check("rst_opcode", OpCode, 0);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetched", PerfFetched, 32'h0);
    check("rst_perf_stall", PerfStall, 32'h0);
`endif
  endtask

  // One cycle: drive at negedge, check at +1, advance the model, wait for next negedge.
  task automatic tick();
    bit          issue, holding, exp_busy, ld;
    logic [31:0] word;
    imem_ack   = ack_now();
    imem_rdata = (imem_ack && m_waiting) ? mem_word(m_addr) : $urandom;
    #1;
    holding  = (m_held.size() != 0);
    issue    = !m_waiting && !holding;
    exp_busy = m_waiting && !imem_ack && IFIDWrite;
    check("req", imem_req, !holding);
    if (!holding) check("addr", imem_addr, m_waiting ? m_addr : m_pc);
    check("busy", FetchBusy, exp_busy);
    check("instr", Instr_IFID, m_instr);
    check("pcp4", PCPlus4_IFID, m_pcp4);
    check("valid", Valid_IFID, m_valid);
    check("decode", {OpCode, Func, RegRS_IFID, RegRT_IFID},
          {m_instr[31:26], m_instr[5:0], m_instr[25:21], m_instr[20:16]});
`ifdef FETCH_PERF_EN
    check("perf_fetched", PerfFetched, m_fetched);
    check("perf_stall", PerfStall, m_stall);
`endif
    ld = 0; word = 32'h0;
    if (exp_busy || holding) m_stall++;
    if (issue) begin
      m_addr = m_pc; m_waiting = 1; m_discard = Redirect; wait_cnt = 0;
      lat = (lat_cfg == 0) ? $urandom_range(1, 3) : lat_cfg;
    end else if (m_waiting) begin
      if (imem_ack) begin
        m_waiting = 0;
        if (!m_discard && !Redirect) begin
          if (IFIDWrite) begin ld = 1; word = imem_rdata; end
          else m_held.push_back(imem_rdata);
        end
        m_discard = 0;
      end else begin
        wait_cnt++;
        if (Redirect) m_discard = 1;
      end
    end else begin
      if (Redirect) m_held.delete();
      else if (IFIDWrite) begin ld = 1; word = m_held.pop_front(); end
    end
    if (BranchFlush) begin
      m_instr = 32'h0; m_valid = 0;
    end else if (ld) begin
      m_instr = word; m_pcp4 = m_pc + 32'd4; m_valid = 1; m_fetched++;
    end
    if (Redirect) m_pc = RedirectPC & ~32'd3;
    else if (ld && PCWrite) m_pc = m_pc + 32'd4;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 0; PCWrite = 1; IFIDWrite = 1; BranchFlush = 0; Redirect = 0;
    RedirectPC = 32'h0; imem_ack = 0; imem_rdata = 32'h0;
    force_ack = 0; lat_cfg = 1; stall_left = 0;
    m_reset();
    repeat (2) @(negedge clk);
    #1 check_reset_values();
    @(negedge clk);
    rst_n = 1;

    // Back-to-back single-cycle acks: 0,4,8,12...
    lat_cfg = 1;
    repeat (12) tick();

    // Slow memory: address held, FetchBusy up, IF/ID keeps old word
    lat_cfg = 3;
    repeat (12) tick();

    // Hazard stall over the ack cycle and the one after it
    lat_cfg = 1;
    for (int i = 0; i < 16; i++) begin
      if (stall_left == 0 && m_waiting && ack_now()) stall_left = 2;
      PCWrite = (stall_left == 0); IFIDWrite = (stall_left == 0);
      tick();
      if (stall_left > 0) stall_left--;
    end
    PCWrite = 1; IFIDWrite = 1;

    // Redirect to 0x40 while a slow fetch is outstanding
    lat_cfg = 3;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_waiting && wait_cnt == 0) found = 1;
      else tick();
    end
    check("reach_wait_for_redirect", found, 1);
    Redirect = 1; RedirectPC = 32'h40;
    tick();
    Redirect = 0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (!m_waiting && m_held.size() == 0) found = 1;
      else tick();
    end
    check("reach_reissue", found, 1);
    #1 check("redirect_addr", imem_addr, 32'h40);
    @(negedge clk);
    m_waiting = m_waiting; // cycle above was spent idle-checking: resync model by one issue
    // The skipped cycle issued 0x40 in the DUT; bring the model along with the same rule.
    m_addr = m_pc; m_waiting = 1; m_discard = 0; wait_cnt = 0; lat = lat_cfg;
    repeat (8) tick();

    // Flush wins over a frozen IF/ID
    IFIDWrite = 0; BranchFlush = 1;
    tick();
    BranchFlush = 0; IFIDWrite = 1;
    check("flush_instr", Instr_IFID, 32'h0);
    check("flush_valid", Valid_IFID, 0);
    check("flush_opcode", OpCode, 0);
    repeat (4) tick();

    // Misaligned redirect near the top of memory, then wrap past 0xFFFF_FFFC
    lat_cfg = 1;
    Redirect = 1; RedirectPC = 32'hFFFF_FFF9;
    tick();
    Redirect = 0;
    repeat (12) tick();

    // Random control traffic and latencies
    lat_cfg = 0;
    for (int i = 0; i < 400; i++) begin
      PCWrite     = ($urandom_range(0, 3) != 0);
      IFIDWrite   = ($urandom_range(0, 3) != 0);
      BranchFlush = ($urandom_range(0, 7) == 0);
      Redirect    = ($urandom_range(0, 9) == 0);
      RedirectPC  = $urandom;
      tick();
    end
    PCWrite = 1; IFIDWrite = 1; BranchFlush = 0; Redirect = 0;

    // Asynchronous reset in the middle of an outstanding fetch
    lat_cfg = 3;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_waiting) found = 1;
      else tick();
    end
    check("reach_wait_for_reset", found, 1);
    #2 rst_n = 0;
    #1 check_reset_values();
    @(negedge clk);
    rst_n = 1;
    m_reset();
    force_ack = 1;   // stale ack right after release must be ignored
    tick();
    force_ack = 0;
    lat_cfg = 1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
